// File: rtl/sprite_pkg.sv
// sprite_pkg: shared defaults, index widths and the sprite mask contents
package sprite_pkg;
    localparam int NUM_SPR_D = 4;
    localparam int SPR_W_D = 16;
    localparam int SPR_H_D = 16;
    localparam int X_W_D = 10;
    localparam int Y_W_D = 10;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    localparam int SID_W_D = idx_w(NUM_SPR_D);
    localparam int ROW_W_D = $clog2(SPR_H_D);
    localparam int COL_W_D = $clog2(SPR_W_D);
    // sprite 0 has a hole at its top-left pixel, sprite 2 at its bottom-left pixel
    function automatic logic mask_bit(input int id, input int row, input int col, input int h);
        return id == 0 ? !(row == 0 && col == 0) :
               id == 2 ? !(row == h - 1 && col == 0) : 1'b1;
    endfunction
endpackage

// File: rtl/sprite_mask_unit_if.sv
// sprite_mask_unit_if: pixel, register-write and result signals of the sprite mask unit
// iWrMirror exists only when SPRITE_MIRROR_EN is defined
interface sprite_mask_unit_if
    import sprite_pkg::*;
#(
    parameter int NUM_SPR = NUM_SPR_D,
    parameter int X_W = X_W_D,
    parameter int Y_W = Y_W_D
);
    localparam int SID_W = idx_w(NUM_SPR);
    logic             iPixelValid;
    logic [X_W-1:0]   iPixelX;
    logic [Y_W-1:0]   iPixelY;
    logic             iWrReq;
    logic [SID_W-1:0] iWrSel;
    logic [X_W-1:0]   iWrX;
    logic [Y_W-1:0]   iWrY;
    logic             iWrVisible;
`ifdef SPRITE_MIRROR_EN
    logic             iWrMirror;
`endif
    logic             oWrAck;
    logic             oValid;
    logic             oMask;
    logic [SID_W-1:0] oSpriteId;
    modport master (
        output iPixelValid, iPixelX, iPixelY, iWrReq, iWrSel, iWrX, iWrY, iWrVisible,
`ifdef SPRITE_MIRROR_EN
        output iWrMirror,
`endif
        input oWrAck, oValid, oMask, oSpriteId
    );
    modport slave (
        input iPixelValid, iPixelX, iPixelY, iWrReq, iWrSel, iWrX, iWrY, iWrVisible,
`ifdef SPRITE_MIRROR_EN
        input iWrMirror,
`endif
        output oWrAck, oValid, oMask, oSpriteId
    );
endinterface

// File: rtl/sprite_mask_rom.sv
// sprite_mask_rom: combinational 1-bit mask lookup addressed by {spriteId,row,col}
module sprite_mask_rom
    import sprite_pkg::*;
#(
    parameter int NUM_SPR = NUM_SPR_D,
    parameter int SPR_W = SPR_W_D,
    parameter int SPR_H = SPR_H_D,
    localparam int SID_W = idx_w(NUM_SPR),
    localparam int ROW_W = $clog2(SPR_H),
    localparam int COL_W = $clog2(SPR_W)
) (
    input  logic [SID_W+ROW_W+COL_W-1:0] addr,
    output logic                         data
);
    assign data = mask_bit(int'(addr[COL_W+ROW_W+:SID_W]), int'(addr[COL_W+:ROW_W]),
                           int'(addr[COL_W-1:0]), SPR_H);
endmodule

// File: rtl/sprite_mask_unit.sv
// sprite_mask_unit: two-stage per-pixel sprite hit test, mask lookup and priority select
// defining SPRITE_MIRROR_EN adds a per-sprite horizontal mirror bit
module sprite_mask_unit
    import sprite_pkg::*;
#(
    parameter int NUM_SPR = NUM_SPR_D,
    parameter int SPR_W = SPR_W_D,
    parameter int SPR_H = SPR_H_D,
    parameter int X_W = X_W_D,
    parameter int Y_W = Y_W_D
) (
    input logic clk,
    input logic rst_n,
    sprite_mask_unit_if.slave bus
);
    localparam int SID_W = idx_w(NUM_SPR);
    localparam int ROW_W = $clog2(SPR_H);
    localparam int COL_W = $clog2(SPR_W);
    localparam logic [SID_W:0] NUM_L = (SID_W + 1)'(NUM_SPR);

    logic [X_W-1:0]     pos_x_q [NUM_SPR];
    logic [X_W-1:0]     pos_x_d [NUM_SPR];
    logic [Y_W-1:0]     pos_y_q [NUM_SPR];
    logic [Y_W-1:0]     pos_y_d [NUM_SPR];
    logic [X_W-1:0]     dx [NUM_SPR];
    logic [Y_W-1:0]     dy [NUM_SPR];
    logic [ROW_W-1:0]   row_q [NUM_SPR];
    logic [ROW_W-1:0]   row_d [NUM_SPR];
    logic [COL_W-1:0]   col_q [NUM_SPR];
    logic [COL_W-1:0]   col_d [NUM_SPR];
    logic [NUM_SPR-1:0] vis_q, vis_d, hit_q, hit_d, wr, rom_bit, eff;
`ifdef SPRITE_MIRROR_EN
    logic [NUM_SPR-1:0] mir_q, mir_d;
`endif
    logic               v1_q, v1_d, valid_q, valid_d, mask_q, mask_d, ack_q, ack_d;
    logic [SID_W-1:0]   id_q, id_d;

    // stage 1 compares against the pre-write registers, so a same-cycle write lands on the next pixel
    always_comb begin
        ack_d = bus.iWrReq && {1'b0, bus.iWrSel} < NUM_L;
        v1_d = bus.iPixelValid;
        for (int k = 0; k < NUM_SPR; k++) begin
            wr[k] = bus.iWrReq && bus.iWrSel == SID_W'(k);
            pos_x_d[k] = wr[k] ? bus.iWrX : pos_x_q[k];
            pos_y_d[k] = wr[k] ? bus.iWrY : pos_y_q[k];
            vis_d[k] = wr[k] ? bus.iWrVisible : vis_q[k];
`ifdef SPRITE_MIRROR_EN
            mir_d[k] = wr[k] ? bus.iWrMirror : mir_q[k];
`endif
            dx[k] = bus.iPixelX - pos_x_q[k];
            dy[k] = bus.iPixelY - pos_y_q[k];
            hit_d[k] = bus.iPixelValid && vis_q[k] && bus.iPixelX >= pos_x_q[k] &&
                       bus.iPixelY >= pos_y_q[k] && dx[k] < X_W'(SPR_W) && dy[k] < Y_W'(SPR_H);
            row_d[k] = dy[k][ROW_W-1:0];
`ifdef SPRITE_MIRROR_EN
            col_d[k] = mir_q[k] ? ~dx[k][COL_W-1:0] : dx[k][COL_W-1:0];
`else
            col_d[k] = dx[k][COL_W-1:0];
`endif
        end
    end

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_rom
        sprite_mask_rom #(.NUM_SPR(NUM_SPR), .SPR_W(SPR_W), .SPR_H(SPR_H)) u_rom (
            .addr({SID_W'(i), row_q[i], col_q[i]}),
            .data(rom_bit[i])
        );
    end

    assign eff = hit_q & rom_bit;

    always_comb begin
        id_d = '0;
        for (int k = NUM_SPR - 1; k >= 0; k--) id_d = eff[k] ? SID_W'(k) : id_d;
        mask_d = |eff;
        valid_d = v1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_q <= '{default: '0};
            pos_y_q <= '{default: '0};
            row_q <= '{default: '0};
            col_q <= '{default: '0};
            vis_q <= '0;
`ifdef SPRITE_MIRROR_EN
            mir_q <= '0;
`endif
            hit_q <= '0;
            v1_q <= 1'b0;
            valid_q <= 1'b0;
            mask_q <= 1'b0;
            id_q <= '0;
            ack_q <= 1'b0;
        end else begin
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            row_q <= row_d;
            col_q <= col_d;
            vis_q <= vis_d;
`ifdef SPRITE_MIRROR_EN
            mir_q <= mir_d;
`endif
            hit_q <= hit_d;
            v1_q <= v1_d;
            valid_q <= valid_d;
            mask_q <= mask_d;
            id_q <= id_d;
            ack_q <= ack_d;
        end
    end

    assign bus.oWrAck = ack_q;
    assign bus.oValid = valid_q;
    assign bus.oMask = mask_q;
    assign bus.oSpriteId = id_q;
endmodule
